// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer.
package debounce_pkg;

  // Stable-cycle requirement used on the board clock.
  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 16;

  // Shortened stable-cycle requirement for simulation.
  localparam int unsigned DEBOUNCE_CICLOS_SIM = 4;

endpackage

// File: rtl/debounce_canal.sv
// One debounce channel: 2-flop synchronizer, stability counter,
// accepted level (estavel) and a one-cycle press pulse on 0->1 acceptance.
module debounce_canal
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clk,
  input  logic reset,
  input  logic bruto,
  output logic nivel,
  output logic pulso
);

  localparam int unsigned LARGURA = $clog2(DEBOUNCE_CICLOS);
  localparam logic [LARGURA-1:0] CONT_MAX = LARGURA'(DEBOUNCE_CICLOS - 1);

  logic               sinc1;
  logic               sinc2;
  logic               estavel;
  logic               estavel_prox;
  logic [LARGURA-1:0] cont;
  logic [LARGURA-1:0] cont_prox;
  logic               pulso_prox;

  // Bring the asynchronous raw level into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= bruto;
      sinc2 <= sinc1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level at the limit.
  // The counter only runs while sinc2 differs from estavel, so it never wraps.
  always_comb begin
    cont_prox    = cont;
    estavel_prox = estavel;
    pulso_prox   = 1'b0;
    if (sinc2 == estavel) begin
      cont_prox = '0;
    end else if (cont == CONT_MAX) begin
      estavel_prox = sinc2;
      cont_prox    = '0;
      pulso_prox   = sinc2;
    end else begin
      cont_prox = cont + 1'b1;
    end
  end

  // Register the counter, accepted level and press pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont    <= '0;
      estavel <= 1'b0;
      pulso   <= 1'b0;
    end else begin
      cont    <= cont_prox;
      estavel <= estavel_prox;
      pulso   <= pulso_prox;
    end
  end

  assign nivel = estavel;

endmodule

// File: rtl/debounce_botoes.sv
// Two-button debouncer. Each button has its own channel; press pulses are
// arbitrated so both outputs are never high together (button 1 wins, a
// colliding button 2 pulse is deferred by one cycle).
module debounce_botoes
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clk,
  input  logic reset,
  input  logic BotaoBruto1,
  input  logic BotaoBruto2,
  output logic SinalBotao1,
  output logic SinalBotao2,
  output logic NivelBotao1,
  output logic NivelBotao2
);

  logic pulso1;
  logic pulso2;
  logic pendente2;

  debounce_canal #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_canal1 (
    .clk  (clk),
    .reset(reset),
    .bruto(BotaoBruto1),
    .nivel(NivelBotao1),
    .pulso(pulso1)
  );

  debounce_canal #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_canal2 (
    .clk  (clk),
    .reset(reset),
    .bruto(BotaoBruto2),
    .nivel(NivelBotao2),
    .pulso(pulso2)
  );

  // Remember a button-2 pulse that lost arbitration; it is replayed next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendente2 <= 1'b0;
    end else begin
      pendente2 <= pulso1 & pulso2;
    end
  end

  // Drive the pulse outputs with button 1 taking priority.
  always_comb begin
    SinalBotao1 = pulso1;
    SinalBotao2 = pendente2 | (pulso2 & ~pulso1);
  end

endmodule

// File: tb/tb_debounce_botoes.sv
// Directed bench for debounce_botoes with DEBOUNCE_CICLOS = 4.
// Observed vector per edge is {SinalBotao1, SinalBotao2, NivelBotao1, NivelBotao2}.
module tb_debounce_botoes;
  import debounce_pkg::*;

  logic clk;
  logic reset;
  logic BotaoBruto1;
  logic BotaoBruto2;
  logic SinalBotao1;
  logic SinalBotao2;
  logic NivelBotao1;
  logic NivelBotao2;

  int unsigned checks;
  int unsigned errors;

  debounce_botoes #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS_SIM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .BotaoBruto1(BotaoBruto1),
    .BotaoBruto2(BotaoBruto2),
    .SinalBotao1(SinalBotao1),
    .SinalBotao2(SinalBotao2),
    .NivelBotao1(NivelBotao1),
    .NivelBotao2(NivelBotao2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {SinalBotao1, SinalBotao2, NivelBotao1, NivelBotao2};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then compare away from the edge.
  task automatic step(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic steps(input string tag, input int unsigned n, input logic [3:0] exp);
    for (int unsigned i = 0; i < n; i++) step(tag, exp);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    BotaoBruto1 = 1'b0;
    BotaoBruto2 = 1'b0;
    #1;
    chk("reset_inicial", 4'b0000);

    // Raw inputs toggle while reset is held: outputs stay 0.
    for (int unsigned i = 0; i < 12; i++) begin
      BotaoBruto1 = ~BotaoBruto1;
      if (i % 3 == 0) BotaoBruto2 = ~BotaoBruto2;
      step("reset_toggle", 4'b0000);
    end
    BotaoBruto1 = 1'b0;
    BotaoBruto2 = 1'b0;
    reset       = 1'b0;
    steps("ocioso", 3, 4'b0000);

    // Clean press on button 1, held 12 cycles.
    BotaoBruto1 = 1'b1;
    steps("b1_prensa_espera", 5, 4'b0000);
    step("b1_prensa_e6", 4'b1010);
    steps("b1_segurado", 6, 4'b0010);

    // Release: level drops at edge 6, no pulse.
    BotaoBruto1 = 1'b0;
    steps("b1_solta_espera", 5, 4'b0010);
    step("b1_solta_e6", 4'b0000);
    steps("b1_solto", 3, 4'b0000);

    // Glitch of 3 cycles is ignored.
    BotaoBruto1 = 1'b1;
    steps("glitch3_alto", 3, 4'b0000);
    BotaoBruto1 = 1'b0;
    steps("glitch3_depois", 8, 4'b0000);

    // Excursion of exactly 4 cycles is the shortest accepted one.
    BotaoBruto1 = 1'b1;
    steps("pulso4_alto", 4, 4'b0000);
    BotaoBruto1 = 1'b0;
    step("pulso4_e5", 4'b0000);
    step("pulso4_e6", 4'b1010);
    steps("pulso4_e7_9", 3, 4'b0010);
    step("pulso4_e10", 4'b0000);
    steps("pulso4_fim", 2, 4'b0000);

    // Simultaneous press: button 1 first, button 2 one cycle later.
    BotaoBruto1 = 1'b1;
    BotaoBruto2 = 1'b1;
    steps("ambos_espera", 5, 4'b0000);
    step("ambos_e6", 4'b1011);
    step("ambos_e7", 4'b0111);
    steps("ambos_segurado", 4, 4'b0011);
    BotaoBruto1 = 1'b0;
    BotaoBruto2 = 1'b0;
    steps("ambos_solta_espera", 5, 4'b0011);
    step("ambos_solta_e6", 4'b0000);
    steps("ambos_solto", 2, 4'b0000);

    // Button 2 alone passes straight through.
    BotaoBruto2 = 1'b1;
    steps("b2_espera", 5, 4'b0000);
    step("b2_e6", 4'b0101);
    steps("b2_segurado", 3, 4'b0001);
    BotaoBruto2 = 1'b0;
    steps("b2_solta_espera", 5, 4'b0001);
    step("b2_solta_e6", 4'b0000);

    // Reset mid-count discards the partial count; held button re-accepted.
    BotaoBruto1 = 1'b1;
    steps("rst_meio_antes", 3, 4'b0000);
    reset = 1'b1;
    #1;
    chk("rst_meio_async", 4'b0000);
    step("rst_meio_ativo", 4'b0000);
    reset = 1'b0;
    steps("rst_meio_espera", 5, 4'b0000);
    step("rst_meio_e6", 4'b1010);
    step("rst_meio_e7", 4'b0010);

    // Asynchronous reset clears an accepted level without a clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_async_nivel", 4'b0000);
    BotaoBruto1 = 1'b0;
    step("rst_async_mantido", 4'b0000);
    reset = 1'b0;
    steps("final", 6, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_botoes.md
DEBOUNCE_BOTOES -- requirements
Module: debounce_botoes

Interface
REQ-001 The block SHALL use one clock, clk, and one asynchronous, active-high reset, reset; these fields are fixed.
REQ-002 Parameter DEBOUNCE_CICLOS, default 16, SHALL be the number of consecutive stable cycles required to accept a level change; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 BotaoBruto1  input  1  raw, asynchronous, bouncing level from push-button 1 (1 = pressed).
REQ-006 BotaoBruto2  input  1  raw, asynchronous, bouncing level from push-button 2 (1 = pressed).
REQ-007 SinalBotao1  output  1  single-cycle press pulse for button 1, the producer side of the SinalBotao1 input of the position logic.
REQ-008 SinalBotao2  output  1  single-cycle press pulse for button 2, the producer side of the SinalBotao2 input of the position logic.
REQ-009 NivelBotao1  output  1  debounced stable level of button 1.
REQ-010 NivelBotao2  output  1  debounced stable level of button 2.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer (sinc1, sinc2) before any other use.
REQ-012 Each channel SHALL hold a stable level (estavel) and a counter of width ceil(log2(DEBOUNCE_CICLOS)).
REQ-013 Edge where sinc2 == estavel: counter SHALL load 0.
REQ-014 Edge where sinc2 != estavel and counter < DEBOUNCE_CICLOS-1: counter SHALL increment by 1.
REQ-015 Edge where sinc2 != estavel and counter == DEBOUNCE_CICLOS-1: estavel SHALL load sinc2, counter SHALL load 0; counter never wraps.
REQ-016 Latency: a clean raw level change SHALL appear on NivelBotaoN at the (2 + DEBOUNCE_CICLOS)-th rising edge after the first edge sampling the new level.
REQ-017 Any raw excursion shorter than DEBOUNCE_CICLOS synchronized cycles SHALL be ignored (no Nivel change, no pulse).
REQ-018 A channel press pulse (pulsoN) SHALL be registered high for exactly one cycle at the same edge estavel changes 0->1; 1->0 changes SHALL produce no pulse.
REQ-019 SinalBotao1 SHALL equal pulso1.
REQ-020 SinalBotao1 and SinalBotao2 SHALL never be high in the same cycle; button 1 has priority.
REQ-021 If pulso1 and pulso2 coincide, a pendente2 flag SHALL set and SinalBotao2 SHALL be high exactly one cycle later; pendente2 then clears.
REQ-022 Otherwise SinalBotao2 SHALL equal pulso2.
REQ-023 Each accepted press SHALL yield exactly one pulse; holding a button SHALL not repeat pulses.
REQ-024 Channels SHALL be independent apart from REQ-020/021.

Reset
REQ-025 While reset is high, all synchronizers, estavel, counters, pulso, pendente2 SHALL be 0, hence all four outputs 0, regardless of clk.
REQ-026 Reset asserted mid-count SHALL discard the partial count; a button still held after reset release SHALL be accepted as a new press after 2 + DEBOUNCE_CICLOS edges.

Structure
REQ-027 A shared package debounce_pkg SHALL hold DEBOUNCE_CICLOS_PADRAO (16) and DEBOUNCE_CICLOS_SIM (4).
REQ-028 Sub-module debounce_canal (synchronizer, counter, estavel, pulso) SHALL be instantiated twice; arbitration and pendente2 reside in debounce_botoes.
REQ-029 Estimated size: 120-200 lines RTL.

Verification (DEBOUNCE_CICLOS = 4, edge 1 = first edge sampling the change)
REQ-030 Reset high with raw inputs toggling -> all outputs 0 throughout.
REQ-031 BotaoBruto1 0->1, held 12 cycles -> SinalBotao1 high only after edge 6, NivelBotao1 = 1 from edge 6, SinalBotao2 stays 0.
REQ-032 BotaoBruto1 high 3 cycles then low (glitch) -> no pulse, NivelBotao1 stays 0.
REQ-033 Both raw inputs 0->1 on same cycle -> SinalBotao1 high after edge 6, SinalBotao2 high after edge 7, never simultaneous.
REQ-034 Held button released -> NivelBotao1 drops after edge 6, no pulse on either output.
REQ-035 Reset pulsed after edge 3 of a press, raw held -> no pulse before reset, one SinalBotao1 pulse 6 edges after reset release.
